// File: rtl/dds_uart_ctrl_pkg.sv
// Shared definitions for the DDS UART command decoder: FSM states,
// command codes, ASCII constants and small byte-classification helpers.
package dds_uart_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CHAN    = 3'd1,
        ST_VAL     = 3'd2,
        ST_COMMIT  = 3'd3,
        ST_DISCARD = 3'd4
    } state_t;

    typedef enum logic {
        CMD_FREQ = 1'b0,
        CMD_WAVE = 1'b1
    } cmd_t;

    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_SP   = 8'h20;
    localparam logic [7:0] ASCII_0    = 8'h30;
    localparam logic [7:0] ASCII_9    = 8'h39;
    localparam logic [7:0] ASCII_F_UC = 8'h46;
    localparam logic [7:0] ASCII_F_LC = 8'h66;
    localparam logic [7:0] ASCII_W_UC = 8'h57;
    localparam logic [7:0] ASCII_W_LC = 8'h77;

    // True for '0'..'9'
    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASCII_0) && (b <= ASCII_9);
    endfunction

    // True for a line terminator (CR or LF)
    function automatic logic is_term(input logic [7:0] b);
        return (b == ASCII_CR) || (b == ASCII_LF);
    endfunction

endpackage

// File: rtl/dds_uart_ctrl_dec_accum.sv
// W-bit saturating decimal accumulator: acc <= acc*10 + digit on en,
// clamps to all-ones and raises a sticky sat flag on overflow; clr
// restarts both for a new number.
import dds_uart_ctrl_pkg::*;

module dds_uart_ctrl_dec_accum #(
    parameter int W = 32
) (
    input  logic         Clk_100M,
    input  logic         Reset,
    input  logic         clr,
    input  logic         en,
    input  logic [3:0]   digit,
    output logic [W-1:0] acc,
    output logic         sat
);

    localparam logic [W+3:0] ACC_MAX = {4'b0000, {W{1'b1}}};

    logic [W-1:0] acc_r;
    logic         sat_r;
    logic [W+3:0] next_s;

    // acc*10 + digit, computed as shifts in W+4 bits so overflow is visible
    always_comb begin
        next_s = ({4'b0000, acc_r} << 3'd3)
               + ({4'b0000, acc_r} << 3'd1)
               + {{W{1'b0}}, digit};
    end

    // Accumulator register; saturation stays set until the next clear
    always_ff @(posedge Clk_100M) begin
        if (Reset) begin
            acc_r <= {W{1'b0}};
            sat_r <= 1'b0;
        end else if (clr) begin
            acc_r <= {W{1'b0}};
            sat_r <= 1'b0;
        end else if (en) begin
            if (next_s > ACC_MAX) begin
                acc_r <= {W{1'b1}};
                sat_r <= 1'b1;
            end else begin
                acc_r <= next_s[W-1:0];
            end
        end
    end

    assign acc = acc_r;
    assign sat = sat_r;

endmodule

// File: rtl/dds_uart_ctrl.sv
// Multi-channel command decoder between the UART receiver and the DDS bank.
// Parses "<F|W><ch><decimal><CR|LF>" lines into per-channel tuning words
// and waveform modes, pulsing Update for the written channel and Error for
// any rejected line.
import dds_uart_ctrl_pkg::*;

module dds_uart_ctrl #(
    parameter int          W         = 32,
    parameter int          NCH       = 2,
    parameter int unsigned DEFAULT_M = 1
) (
    input  logic               Clk_100M,
    input  logic               Reset,
    input  logic [7:0]         RxData,
    input  logic               RxBusy,
    output logic [NCH*W-1:0]   M,
    output logic [NCH*2-1:0]   Wave,
    output logic [NCH-1:0]     Update,
    output logic               Error
);

    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    // byte capture
    logic           busy_q_r;
    logic           strb_q_r;
    logic [7:0]     byte_q_r;
    logic           strobe_s;

    // FSM
    state_t         state_r, state_n;
    cmd_t           cmd_r, cmd_n;
    logic [CHW-1:0] ch_r, ch_n;
    logic           ndig_r, ndig_n;

    // byte classification of the captured byte
    logic [3:0]     digit_s;
    logic           is_digit_s;
    logic           is_term_s;
    logic           ch_ok_s;

    // accumulator
    logic           acc_clr_s;
    logic           acc_en_s;
    logic [W-1:0]   acc_s;
    logic           sat_s;

    // commit / error decisions
    logic           line_err_s;
    logic           commit_err_s;
    logic           wr_m_s;
    logic           wr_wave_s;

    // output registers
    logic [W-1:0]   m_r    [NCH];
    logic [1:0]     wave_r [NCH];
    logic [NCH-1:0] update_r;
    logic           error_r;

    // A new byte is announced by the falling edge of RxBusy
    assign strobe_s = busy_q_r & ~RxBusy;

    // Edge detector and byte latch; the FSM sees the byte one cycle later
    always_ff @(posedge Clk_100M) begin
        if (Reset) begin
            busy_q_r <= 1'b0;
            strb_q_r <= 1'b0;
            byte_q_r <= 8'h00;
        end else begin
            busy_q_r <= RxBusy;
            strb_q_r <= strobe_s;
            if (strobe_s) begin
                byte_q_r <= RxData;
            end
        end
    end

    // Decode the captured byte; ASCII digits carry their value in the low nibble
    always_comb begin
        digit_s    = byte_q_r[3:0];
        is_digit_s = is_digit(byte_q_r);
        is_term_s  = is_term(byte_q_r);
        ch_ok_s    = is_digit_s && ({28'd0, digit_s} < 32'(NCH));
    end

    dds_uart_ctrl_dec_accum #(
        .W (W)
    ) u_accum (
        .Clk_100M (Clk_100M),
        .Reset    (Reset),
        .clr      (acc_clr_s),
        .en       (acc_en_s),
        .digit    (digit_s),
        .acc      (acc_s),
        .sat      (sat_s)
    );

    // FSM state and line-context registers
    always_ff @(posedge Clk_100M) begin
        if (Reset) begin
            state_r <= ST_IDLE;
            cmd_r   <= CMD_FREQ;
            ch_r    <= {CHW{1'b0}};
            ndig_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            cmd_r   <= cmd_n;
            ch_r    <= ch_n;
            ndig_r  <= ndig_n;
        end
    end

    // Next-state, accumulator control and commit decisions
    always_comb begin
        state_n      = state_r;
        cmd_n        = cmd_r;
        ch_n         = ch_r;
        ndig_n       = ndig_r;
        acc_clr_s    = 1'b0;
        acc_en_s     = 1'b0;
        line_err_s   = 1'b0;
        commit_err_s = 1'b0;
        wr_m_s       = 1'b0;
        wr_wave_s    = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (strb_q_r) begin
                    if ((byte_q_r == ASCII_F_UC) || (byte_q_r == ASCII_F_LC)) begin
                        state_n = ST_CHAN;
                        cmd_n   = CMD_FREQ;
                    end else if ((byte_q_r == ASCII_W_UC) || (byte_q_r == ASCII_W_LC)) begin
                        state_n = ST_CHAN;
                        cmd_n   = CMD_WAVE;
                    end else if (is_term_s || (byte_q_r == ASCII_SP)) begin
                        state_n = ST_IDLE;
                    end else begin
                        state_n    = ST_DISCARD;
                        line_err_s = 1'b1;
                    end
                end else begin
                    state_n = ST_IDLE;
                end
            end

            ST_CHAN: begin
                if (strb_q_r) begin
                    if (ch_ok_s) begin
                        state_n   = ST_VAL;
                        ch_n      = digit_s[CHW-1:0];
                        ndig_n    = 1'b0;
                        acc_clr_s = 1'b1;
                    end else if (is_term_s) begin
                        state_n    = ST_IDLE;
                        line_err_s = 1'b1;
                    end else begin
                        state_n    = ST_DISCARD;
                        line_err_s = 1'b1;
                    end
                end else begin
                    state_n = ST_CHAN;
                end
            end

            ST_VAL: begin
                if (strb_q_r) begin
                    if (is_digit_s) begin
                        acc_en_s = 1'b1;
                        ndig_n   = 1'b1;
                    end else if (is_term_s) begin
                        state_n = ST_COMMIT;
                    end else begin
                        state_n    = ST_DISCARD;
                        line_err_s = 1'b1;
                    end
                end else begin
                    state_n = ST_VAL;
                end
            end

            // Single cycle: write the selected register or flag the line
            ST_COMMIT: begin
                state_n = ST_IDLE;
                if (!ndig_r) begin
                    commit_err_s = 1'b1;
                end else if (cmd_r == CMD_FREQ) begin
                    wr_m_s       = 1'b1;
                    commit_err_s = sat_s;
                end else if (|acc_s[W-1:2]) begin
                    commit_err_s = 1'b1;
                end else begin
                    wr_wave_s = 1'b1;
                end
            end

            // Swallow the rest of a bad line without further errors
            ST_DISCARD: begin
                if (strb_q_r && is_term_s) begin
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_DISCARD;
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Per-channel output registers and one-cycle Update/Error pulses
    always_ff @(posedge Clk_100M) begin
        if (Reset) begin
            for (int c = 0; c < NCH; c++) begin
                m_r[c]    <= W'(DEFAULT_M);
                wave_r[c] <= 2'b00;
            end
            update_r <= {NCH{1'b0}};
            error_r  <= 1'b0;
        end else begin
            error_r <= line_err_s | commit_err_s;
            for (int c = 0; c < NCH; c++) begin
                if (ch_r == CHW'(c)) begin
                    update_r[c] <= wr_m_s | wr_wave_s;
                    if (wr_m_s) begin
                        m_r[c] <= acc_s;
                    end
                    if (wr_wave_s) begin
                        wave_r[c] <= acc_s[1:0];
                    end
                end else begin
                    update_r[c] <= 1'b0;
                end
            end
        end
    end

    // Pack the channel registers onto the flat output buses
    for (genvar g = 0; g < NCH; g++) begin : g_pack
        assign M[g*W +: W]    = m_r[g];
        assign Wave[g*2 +: 2] = wave_r[g];
    end

    assign Update = update_r;
    assign Error  = error_r;

endmodule

// File: tb/tb_dds_uart_ctrl.sv
// Directed bench for dds_uart_ctrl (W=32, NCH=2): sends ASCII command lines
// byte by byte and checks registers, pulse counts and commit latency.
module tb_dds_uart_ctrl;

    logic        Clk_100M = 1'b0;
    logic        Reset    = 1'b1;
    logic [7:0]  RxData   = 8'h00;
    logic        RxBusy   = 1'b0;
    logic [63:0] M;
    logic [3:0]  Wave;
    logic [1:0]  Update;
    logic        Error;

    int tests = 0;
    int fails = 0;

    // pulse counters owned by the monitor
    int upd0_cnt  = 0;
    int upd1_cnt  = 0;
    int err_cnt   = 0;
    int both_cnt  = 0;
    int multi_cnt = 0;

    // snapshots owned by the initial block
    int s_u0, s_u1, s_e, s_b;
    int          lat_r;
    logic [1:0]  upd_first;

    dds_uart_ctrl #(.W(32), .NCH(2), .DEFAULT_M(1)) dut (
        .Clk_100M (Clk_100M),
        .Reset    (Reset),
        .RxData   (RxData),
        .RxBusy   (RxBusy),
        .M        (M),
        .Wave     (Wave),
        .Update   (Update),
        .Error    (Error)
    );

    always #5 Clk_100M = ~Clk_100M;

    // Count output pulses on the falling edge
    always @(negedge Clk_100M) begin
        if (Update[0]) upd0_cnt <= upd0_cnt + 1;
        if (Update[1]) upd1_cnt <= upd1_cnt + 1;
        if (Error) err_cnt <= err_cnt + 1;
        if (Error && (Update != 2'b00)) both_cnt <= both_cnt + 1;
        if (Update == 2'b11) multi_cnt <= multi_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One UART byte: busy for a few cycles, then a falling edge and a quiet gap;
    // records on which falling edge after the strobe Update first goes high.
    task automatic send_byte(input logic [7:0] b);
        @(posedge Clk_100M); #1;
        RxData = b;
        RxBusy = 1'b1;
        repeat (3) @(posedge Clk_100M);
        #1;
        RxBusy    = 1'b0;
        lat_r     = 0;
        upd_first = 2'b00;
        for (int k = 1; k <= 12; k++) begin
            @(negedge Clk_100M);
            if ((lat_r == 0) && (Update != 2'b00)) begin
                lat_r     = k;
                upd_first = Update;
            end
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i]);
        end
    endtask

    task automatic snap();
        s_u0 = upd0_cnt;
        s_u1 = upd1_cnt;
        s_e  = err_cnt;
        s_b  = both_cnt;
    endtask

    task automatic chk_pulses(input string tag, input int u0, input int u1, input int e);
        chk({tag, ".upd0"}, 64'(upd0_cnt - s_u0), 64'(u0));
        chk({tag, ".upd1"}, 64'(upd1_cnt - s_u1), 64'(u1));
        chk({tag, ".err"},  64'(err_cnt - s_e),   64'(e));
    endtask

    initial begin
        // reset state
        repeat (3) @(posedge Clk_100M);
        #1 Reset = 1'b0;
        repeat (2) @(posedge Clk_100M);
        @(negedge Clk_100M);
        chk("rst.M",      M,              {32'd1, 32'd1});
        chk("rst.Wave",   64'(Wave),      64'd0);
        chk("rst.Update", 64'(Update),    64'd0);
        chk("rst.Error",  64'(Error),     64'd0);
        snap();
        repeat (20) @(posedge Clk_100M);
        chk_pulses("idle", 0, 0, 0);

        // blank bytes in IDLE are ignored silently
        snap();
        send_byte(8'h20);
        send_byte(8'h0A);
        chk_pulses("blank", 0, 0, 0);

        // basic frequency write with commit latency
        snap();
        send_str("F01000");
        send_byte(8'h0D);
        chk("f0.lat",    64'(lat_r),     64'd4);
        chk("f0.first",  64'(upd_first), 64'd1);
        chk("f0.M0",     64'(M[31:0]),   64'd1000);
        chk("f0.M1",     64'(M[63:32]),  64'd1);
        chk_pulses("f0", 1, 0, 0);

        // largest value that fits, lowercase command
        snap();
        send_str("f14294967295");
        send_byte(8'h0D);
        chk("max.M1", 64'(M[63:32]), 64'hFFFF_FFFF);
        chk_pulses("max", 0, 1, 0);

        // one past the maximum saturates; equal value still updates, with Error
        snap();
        send_str("F14294967296");
        send_byte(8'h0A);
        chk("sat.M1",   64'(M[63:32]),       64'hFFFF_FFFF);
        chk("sat.both", 64'(both_cnt - s_b), 64'd1);
        chk_pulses("sat", 0, 1, 1);

        // leading zeros
        snap();
        send_str("F1007");
        send_byte(8'h0D);
        chk("lz.M1", 64'(M[63:32]), 64'd7);
        chk("lz.M0", 64'(M[31:0]),  64'd1000);
        chk_pulses("lz", 0, 1, 0);

        // waveform write, then an out-of-range waveform
        snap();
        send_str("W13");
        send_byte(8'h0D);
        chk("w13.Wave", 64'(Wave), 64'hC);
        chk_pulses("w13", 0, 1, 0);
        snap();
        send_str("w15");
        send_byte(8'h0D);
        chk("w15.Wave", 64'(Wave), 64'hC);
        chk_pulses("w15", 0, 0, 1);

        // rejected lines: one Error each, no register change
        snap();
        send_str("F2 5");
        send_byte(8'h0D);
        chk_pulses("badch", 0, 0, 1);
        snap();
        send_str("Fx");
        send_byte(8'h0D);
        chk_pulses("nondig", 0, 0, 1);
        snap();
        send_str("F0");
        send_byte(8'h0D);
        chk_pulses("nodig", 0, 0, 1);
        snap();
        send_str("Q");
        send_byte(8'h0D);
        chk_pulses("badcmd", 0, 0, 1);
        snap();
        send_str("F");
        send_byte(8'h0D);
        chk_pulses("termch", 0, 0, 1);
        chk("bad.M", M, {32'd7, 32'd1000});

        // decoder is back in IDLE: a good line is accepted
        snap();
        send_str("W02");
        send_byte(8'h0D);
        chk("w02.Wave", 64'(Wave), 64'hE);
        chk_pulses("w02", 1, 0, 0);

        // reset mid-line abandons it
        snap();
        send_str("F0123");
        @(posedge Clk_100M); #1 Reset = 1'b1;
        @(posedge Clk_100M); #1 Reset = 1'b0;
        send_byte(8'h0D);
        chk("mid.M",    M,         {32'd1, 32'd1});
        chk("mid.Wave", 64'(Wave), 64'd0);
        chk_pulses("mid", 0, 0, 0);

        chk("onehot", 64'(multi_cnt), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
